// File: rtl/resource_update_scheduler_pkg.sv
// Shared definitions for the resource update scheduler.
//   - op encoding for the per-requester pending-op registers
//   - FSM state encoding for the slot sequencer
package resource_update_scheduler_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_NONE = 2'd0;
  localparam op_t OP_INC  = 2'd1;
  localparam op_t OP_DEC  = 2'd2;
  localparam op_t OP_SET  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ISSUE = 2'd2
  } state_t;

endpackage

// File: rtl/resource_update_scheduler_rr_arbiter.sv
// Combinational round-robin find-first.
// Scans req starting at rr_ptr, wrapping modulo NUM_REQ, and reports the
// first set index.
// Ports:
//   req    in  NUM_REQ  request vector (pending flags)
//   rr_ptr in  SEL_W    index to start the search from (< NUM_REQ)
//   found  out 1        some request is set
//   idx    out SEL_W    first set index at or after rr_ptr (0 when !found)
module resource_update_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  // One extra bit so rr_ptr + j (at most 2*NUM_REQ-2) never overflows
  // before the modulo fold.
  logic [SEL_W:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand = {1'b0, rr_ptr} + (SEL_W+1)'(j);
      if (cand >= (SEL_W+1)'(NUM_REQ)) begin
        cand = cand - (SEL_W+1)'(NUM_REQ);
      end
      if (!found && req[cand[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/resource_update_scheduler.sv
// Resource update scheduler: time-multiplexes inc/dec/fast/setval requests
// from NUM_REQ regulators onto one shared resource update port. Requests
// are latched as sticky pending ops (last request wins) and served one per
// update slot in round-robin order; a prescaler sets the slot rate.
//
// Optional feature macro: SCHED_DROP_STATS_EN adds drop_count, a saturating
// count of pending ops overwritten before being served.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              1 = slots issued; 0 = prescaler held at 0
//   req_inc/dec/fast/set per-requester requests (NUM_REQ each)
//   out_inc/dec/fast/setval registered op pulse to the resource
//   out_sel             index of the requester being served
//   out_valid           one-cycle strobe marking an issued op
//   grant               one-hot grant, coincident with out_valid
//   pending             per-requester pending-op flags
//   drop_count          (SCHED_DROP_STATS_EN only) overwritten-op count
//
// state | meaning
// IDLE  | enable low, prescaler held at 0, nothing issued
// COUNT | prescaler running towards TICK_DIV-1
// ISSUE | one-cycle arbitration; winning op is registered onto the outputs
module resource_update_scheduler
  import resource_update_scheduler_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 16,
  parameter int SEL_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_inc,
  input  logic [NUM_REQ-1:0] req_dec,
  input  logic [NUM_REQ-1:0] req_fast,
  input  logic [NUM_REQ-1:0] req_set,
  output logic               out_inc,
  output logic               out_dec,
  output logic               out_fast,
  output logic               out_setval,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] pending
`ifdef SCHED_DROP_STATS_EN
  ,
  output logic [7:0]         drop_count
`endif
);

  localparam int PS_W = $clog2(TICK_DIV);

  state_t             state, state_nxt;
  logic [PS_W-1:0]    presc, presc_nxt;
  op_t                op_q [NUM_REQ];
  logic [NUM_REQ-1:0] fast_q;
  logic [SEL_W-1:0]   rr_ptr;

  logic               arb_found;
  logic [SEL_W-1:0]   arb_idx;
  logic               issue;
  logic [NUM_REQ-1:0] grant_nxt;
  logic [NUM_REQ-1:0] new_req;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pending[i] = (op_q[i] != OP_NONE);
      new_req[i] = req_set[i] | (req_inc[i] ^ req_dec[i]);
    end
  end

  resource_update_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_rr_arbiter (
    .req    (pending),
    .rr_ptr (rr_ptr),
    .found  (arb_found),
    .idx    (arb_idx)
  );

  assign issue = (state == ISSUE) && arb_found;

  always_comb begin
    grant_nxt = '0;
    if (issue) begin
      grant_nxt[arb_idx] = 1'b1;
    end
  end

  // Slot sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      presc <= '0;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    case (state)
      IDLE: begin
        presc_nxt = '0;
        if (enable) state_nxt = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          state_nxt = IDLE;
          presc_nxt = '0;
        end else if (presc == PS_W'(TICK_DIV-1)) begin
          state_nxt = ISSUE;
          presc_nxt = '0;
        end else begin
          presc_nxt = presc + PS_W'(1);
        end
      end
      ISSUE: begin
        presc_nxt = '0;
        state_nxt = enable ? COUNT : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        presc_nxt = '0;
      end
    endcase
  end

  // Pending-op capture. A new request beats the clear from a grant, so a
  // request arriving on the granted index in the ISSUE cycle stays pending
  // while the old op goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) op_q[i] <= OP_NONE;
      fast_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_set[i]) begin
          op_q[i]   <= OP_SET;
          fast_q[i] <= 1'b0;
        end else if (req_inc[i] ^ req_dec[i]) begin
          op_q[i]   <= req_inc[i] ? OP_INC : OP_DEC;
          fast_q[i] <= req_fast[i];
        end else if (grant_nxt[i]) begin
          op_q[i]   <= OP_NONE;
          fast_q[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer and registered update port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      out_valid  <= 1'b0;
      out_inc    <= 1'b0;
      out_dec    <= 1'b0;
      out_fast   <= 1'b0;
      out_setval <= 1'b0;
      out_sel    <= '0;
      grant      <= '0;
    end else begin
      out_valid  <= issue;
      grant      <= grant_nxt;
      out_sel    <= issue ? arb_idx : '0;
      out_inc    <= issue && (op_q[arb_idx] == OP_INC);
      out_dec    <= issue && (op_q[arb_idx] == OP_DEC);
      out_setval <= issue && (op_q[arb_idx] == OP_SET);
      out_fast   <= issue && fast_q[arb_idx] &&
                    ((op_q[arb_idx] == OP_INC) || (op_q[arb_idx] == OP_DEC));
      if (issue) begin
        rr_ptr <= (arb_idx == SEL_W'(NUM_REQ-1)) ? '0 : arb_idx + SEL_W'(1);
      end
    end
  end

`ifdef SCHED_DROP_STATS_EN
  // A pending op is dropped when a new request replaces it, unless that
  // op is being granted in the same cycle (it still goes out).
  logic [3:0] drop_sum;
  logic [8:0] drop_acc;

  always_comb begin
    drop_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      drop_sum = drop_sum + 4'(new_req[i] & pending[i] & ~grant_nxt[i]);
    end
    drop_acc = {1'b0, drop_count} + 9'(drop_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_acc[8] ? 8'hFF : drop_acc[7:0];
    end
  end
`else
  logic unused_new_req;
  assign unused_new_req = ^new_req;
`endif

endmodule

// File: tb/tb_resource_update_scheduler.sv
module tb_resource_update_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int TICK_DIV = 4;
  localparam int SEL_W    = 2;
  localparam int SLOT     = TICK_DIV + 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [NUM_REQ-1:0] req_inc = '0;
  logic [NUM_REQ-1:0] req_dec = '0;
  logic [NUM_REQ-1:0] req_fast = '0;
  logic [NUM_REQ-1:0] req_set = '0;
  logic               out_inc, out_dec, out_fast, out_setval, out_valid;
  logic [SEL_W-1:0]   out_sel;
  logic [NUM_REQ-1:0] grant, pending;
`ifdef SCHED_DROP_STATS_EN
  logic [7:0]         drop_count;
`endif

  resource_update_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .TICK_DIV (TICK_DIV),
    .SEL_W    (SEL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req_inc    (req_inc),
    .req_dec    (req_dec),
    .req_fast   (req_fast),
    .req_set    (req_set),
    .out_inc    (out_inc),
    .out_dec    (out_dec),
    .out_fast   (out_fast),
    .out_setval (out_setval),
    .out_sel    (out_sel),
    .out_valid  (out_valid),
    .grant      (grant),
    .pending    (pending)
`ifdef SCHED_DROP_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEL_W-1:0]   sel;
    logic [NUM_REQ-1:0] grant;
    logic inc, dec, fast, setv;
  } exp_t;

  exp_t sb[$];
  int   strobe_log[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every strobe pops the next expected op.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      exp_t act, exp;
      act = {out_sel, grant, out_inc, out_dec, out_fast, out_setval};
      strobe_cnt++;
      strobe_log.push_back(cyc);
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_strobe actual=%h required=none", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) $display("FAIL strobe_fields actual=%h required=%h", act, exp);
        else n_pass++;
      end
      n_total++;
      if ((int'(out_inc) + int'(out_dec) + int'(out_setval)) != 1 ||
          (out_fast && !(out_inc || out_dec)))
        $display("FAIL op_exclusive actual=%b%b%b%b required=one_op", out_inc, out_dec, out_fast, out_setval);
      else n_pass++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int sel, input logic inc, input logic dec,
                          input logic fast, input logic setv);
    exp_t e;
    logic [NUM_REQ-1:0] g;
    g = '0;
    g[sel] = 1'b1;
    e = {SEL_W'(sel), g, inc, dec, fast, setv};
    sb.push_back(e);
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_total++;
    if (strobe_cnt < target) $display("FAIL strobe_timeout actual=%0d required=%0d", strobe_cnt, target);
    else n_pass++;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_total++;
    if ({out_valid, out_inc, out_dec, out_fast, out_setval, out_sel, grant, pending} !== '0)
      $display("FAIL reset_outputs actual=%b required=0",
               {out_valid, out_inc, out_dec, out_fast, out_setval, out_sel, grant, pending});
    else n_pass++;
`ifdef SCHED_DROP_STATS_EN
    n_total++;
    if (drop_count !== 8'd0) $display("FAIL reset_drop actual=%0d required=0", drop_count);
    else n_pass++;
`endif
    rst = 1'b0;
    repeat (10) tick();
    n_total++;
    if (strobe_cnt !== 0) $display("FAIL reset_quiet actual=%0d required=0", strobe_cnt);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int base;
    go_idle();
    req_dec = 4'hF;
    tick();
    req_dec = '0;
    for (int k = 0; k < NUM_REQ; k++) push_exp(k, 1'b0, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (pending !== 4'hF) $display("FAIL rr_pending actual=%b required=1111", pending);
    else n_pass++;
    strobe_log.delete();
    base = strobe_cnt;
    enable = 1'b1;
    wait_strobes(base + 4, 4 * SLOT + 10);
    for (int k = 1; k < strobe_log.size(); k++) begin
      n_total++;
      if (strobe_log[k] - strobe_log[k-1] != SLOT)
        $display("FAIL rr_spacing actual=%0d required=%0d", strobe_log[k] - strobe_log[k-1], SLOT);
      else n_pass++;
    end
    go_idle();
    n_total++;
    if (pending !== 4'h0) $display("FAIL rr_cleared actual=%b required=0000", pending);
    else n_pass++;
    // rr_ptr back at 0: with 0 and 3 pending, 0 must go first
    req_inc = 4'b1001;
    tick();
    req_inc = '0;
    push_exp(0, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(3, 1'b1, 1'b0, 1'b0, 1'b0);
    base = strobe_cnt;
    enable = 1'b1;
    wait_strobes(base + 2, 2 * SLOT + 10);
    go_idle();
  endtask

  task automatic test_single_inc();
    int c;
    req_inc[2] = 1'b1;
    tick();
    req_inc = '0;
    n_total++;
    if (pending !== 4'b0100) $display("FAIL single_pending actual=%b required=0100", pending);
    else n_pass++;
    push_exp(2, 1'b1, 1'b0, 1'b0, 1'b0);
    strobe_log.delete();
    c = cyc;
    enable = 1'b1;
    wait_strobes(strobe_cnt + 1, 2 * SLOT + 10);
    n_total++;
    if (strobe_log.size() == 0 || strobe_log[0] != c + TICK_DIV + 2)
      $display("FAIL single_latency actual=%0d required=%0d",
               strobe_log.size() ? strobe_log[0] - c : -1, TICK_DIV + 2);
    else n_pass++;
    n_total++;
    if (pending !== 4'b0000) $display("FAIL single_cleared actual=%b required=0000", pending);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_overwrite();
    int base;
    req_inc[1] = 1'b1;
    tick();
    req_inc = '0;
    req_dec[1] = 1'b1;
    tick();
    req_dec = '0;
    req_inc[3] = 1'b1;
    req_dec[3] = 1'b1;
    tick();
    req_inc = '0;
    req_dec = '0;
    n_total++;
    if (pending !== 4'b0010) $display("FAIL ovw_pending actual=%b required=0010", pending);
    else n_pass++;
    push_exp(1, 1'b0, 1'b1, 1'b0, 1'b0);
    base = strobe_cnt;
    enable = 1'b1;
    wait_strobes(base + 1, 2 * SLOT + 10);
    repeat (3 * SLOT) tick();
    n_total++;
    if (strobe_cnt !== base + 1) $display("FAIL ovw_extra actual=%0d required=%0d", strobe_cnt - base, 1);
    else n_pass++;
`ifdef SCHED_DROP_STATS_EN
    n_total++;
    if (drop_count !== 8'd1) $display("FAIL drop_count actual=%0d required=1", drop_count);
    else n_pass++;
`endif
    go_idle();
  endtask

  task automatic test_set_priority();
    req_set[0]  = 1'b1;
    req_inc[0]  = 1'b1;
    req_fast[0] = 1'b1;
    tick();
    req_set = '0;
    req_inc = '0;
    req_fast = '0;
    push_exp(0, 1'b0, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    wait_strobes(strobe_cnt + 1, 2 * SLOT + 10);
    go_idle();
  endtask

  task automatic test_enable_hold();
    int base, c;
    req_inc[2]  = 1'b1;
    req_fast[2] = 1'b1;
    tick();
    req_inc = '0;
    req_fast = '0;
    push_exp(2, 1'b1, 1'b0, 1'b1, 1'b0);
    base = strobe_cnt;
    repeat (40) tick();
    n_total++;
    if (strobe_cnt !== base) $display("FAIL hold_no_strobe actual=%0d required=0", strobe_cnt - base);
    else n_pass++;
    n_total++;
    if (pending !== 4'b0100) $display("FAIL hold_pending actual=%b required=0100", pending);
    else n_pass++;
    strobe_log.delete();
    c = cyc;
    enable = 1'b1;
    // Drop enable during the ISSUE cycle: the strobe must still go out.
    repeat (TICK_DIV + 1) tick();
    enable = 1'b0;
    wait_strobes(base + 1, 10);
    n_total++;
    if (strobe_log.size() == 0 || strobe_log[0] != c + TICK_DIV + 2)
      $display("FAIL hold_latency actual=%0d required=%0d",
               strobe_log.size() ? strobe_log[0] - c : -1, TICK_DIV + 2);
    else n_pass++;
    go_idle();
  endtask

  task automatic test_reset_mid();
    int base;
    bit seen = 0;
    req_dec[1] = 1'b1;
    tick();
    req_dec = '0;
    enable = 1'b1;
    for (int k = 0; k < 3 * SLOT && !seen; k++) begin
      tick();
      if (out_valid) seen = 1;
    end
    n_total++;
    if (!seen || out_sel !== 2'd1) $display("FAIL midrst_strobe actual=%0d/%0d required=1/1", seen, out_sel);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({out_valid, out_inc, out_dec, out_fast, out_setval, out_sel, grant, pending} !== '0)
      $display("FAIL midrst_clear actual=%b required=0",
               {out_valid, out_inc, out_dec, out_fast, out_setval, out_sel, grant, pending});
    else n_pass++;
    tick();
    rst = 1'b0;
    base = strobe_cnt;
    repeat (3 * SLOT) tick();
    n_total++;
    if (strobe_cnt !== base) $display("FAIL midrst_quiet actual=%0d required=0", strobe_cnt - base);
    else n_pass++;
    // rr_ptr reset to 0: requester 1 must be served before 3
    req_inc = 4'b1010;
    tick();
    req_inc = '0;
    push_exp(1, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp(3, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_strobes(base + 2, 3 * SLOT + 10);
    go_idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_inc();
    test_overwrite();
    test_set_priority();
    test_enable_hold();
    test_reset_mid();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_leftover actual=%0d required=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
